// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB write-back, ID read-port and debug bundle for wb_regfile
interface wb_regfile_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 32
);
    logic [DW-1:0]    ALUresOut;
    logic [DW-1:0]    Data;
    logic [4:0]       DestReg;
    logic             WrReg;
    logic             DataSrc;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [DW-1:0]    rs_data;
    logic [DW-1:0]    rt_data;
    logic [DW-1:0]    wb_value;
    logic [4:0]       dbg_addr;
    logic [DW-1:0]    dbg_data;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output ALUresOut, Data, DestReg, WrReg, DataSrc, rs_addr, rt_addr, dbg_addr,
        input  rs_data, rt_data, wb_value, dbg_data, retire_cnt
    );

    modport slave (
        input  ALUresOut, Data, DestReg, WrReg, DataSrc, rs_addr, rt_addr, dbg_addr,
        output rs_data, rt_data, wb_value, dbg_data, retire_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 32-entry GPR file with WB->ID bypass, debug port, retire counter
module wb_regfile #(
    parameter int DW    = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    logic [DW-1:0]    regs [NREG];
    logic [DW-1:0]    wb_sel;
    logic [DW-1:0]    dbg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             commit;

    always_comb begin
        wb_sel = bus.DataSrc ? bus.Data : bus.ALUresOut;
    end

    // Register 0 is never written, so a write to it neither commits nor counts.
    always_comb begin
        commit = bus.WrReg && (bus.DestReg != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            dbg_q <= '0;
            cnt_q <= '0;
        end else begin
            // Debug read samples the array before this edge's commit lands.
            dbg_q <= (bus.dbg_addr == 5'd0) ? '0 : regs[bus.dbg_addr];
            if (commit) begin
                regs[bus.DestReg] <= wb_sel;
                cnt_q             <= cnt_q + CNT_W'(1);
            end
        end
    end

    // The bypass keys on WrReg alone; the address-zero term ahead of it keeps
    // a write aimed at register 0 from leaking onto a read of register 0.
    always_comb begin
        if (bus.rs_addr == 5'd0) begin
            bus.rs_data = '0;
        end else if (bus.WrReg && (bus.DestReg == bus.rs_addr)) begin
            bus.rs_data = wb_sel;
        end else begin
            bus.rs_data = regs[bus.rs_addr];
        end
    end

    always_comb begin
        if (bus.rt_addr == 5'd0) begin
            bus.rt_data = '0;
        end else if (bus.WrReg && (bus.DestReg == bus.rt_addr)) begin
            bus.rt_data = wb_sel;
        end else begin
            bus.rt_data = regs[bus.rt_addr];
        end
    end

    assign bus.wb_value   = wb_sel;
    assign bus.dbg_data   = dbg_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized self-checking bench for wb_regfile against an array reference model
module tb_wb_regfile;
    logic clk;
    logic rst;

    wb_regfile_if #(.DW(32), .CNT_W(32)) bus ();
    wb_regfile_if #(.DW(32), .CNT_W(4))  bus4 ();

    wb_regfile #(.DW(32), .NREG(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.DW(32), .NREG(32), .CNT_W(4)) dut_w4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.ALUresOut = bus.ALUresOut;
    assign bus4.Data      = bus.Data;
    assign bus4.DestReg   = bus.DestReg;
    assign bus4.WrReg     = bus.WrReg;
    assign bus4.DataSrc   = bus.DataSrc;
    assign bus4.rs_addr   = bus.rs_addr;
    assign bus4.rt_addr   = bus.rt_addr;
    assign bus4.dbg_addr  = bus.dbg_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    logic [31:0] m_regs [32];
    logic [31:0] m_dbg;
    int unsigned m_cnt;

    logic        t_rst;
    logic        t_wr;
    logic        t_src;
    logic [31:0] t_alu;
    logic [31:0] t_dat;
    logic [4:0]  t_dest;
    logic [4:0]  t_rs;
    logic [4:0]  t_rt;
    logic [4:0]  t_dbg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        return t_src ? t_dat : t_alu;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (t_wr && t_dest == a) return exp_wb();
        return m_regs[a];
    endfunction

    task automatic drive(input logic r, input logic wr, input logic src,
                         input logic [31:0] alu, input logic [31:0] dat,
                         input logic [4:0] dest, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dbg);
        t_rst = r; t_wr = wr; t_src = src; t_alu = alu; t_dat = dat;
        t_dest = dest; t_rs = rs; t_rt = rt; t_dbg = dbg;
        rst           = r;
        bus.WrReg     = wr;
        bus.DataSrc   = src;
        bus.ALUresOut = alu;
        bus.Data      = dat;
        bus.DestReg   = dest;
        bus.rs_addr   = rs;
        bus.rt_addr   = rt;
        bus.dbg_addr  = dbg;
    endtask

    // Combinational checks, taken mid-cycle.
    task automatic pre_checks();
        #4;
        chk("wb_value", bus.wb_value, exp_wb());
        chk("rs_data", bus.rs_data, exp_read(t_rs));
        chk("rt_data", bus.rt_data, exp_read(t_rt));
    endtask

    // Advance through one edge, update the model, then check registered outputs.
    task automatic post_checks();
        @(posedge clk);
        if (t_rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_dbg = 32'd0;
            m_cnt = 0;
        end else begin
            m_dbg = m_regs[t_dbg];
            if (t_wr && t_dest != 5'd0) begin
                m_regs[t_dest] = exp_wb();
                m_cnt++;
            end
        end
        #1;
        chk("dbg_data", bus.dbg_data, m_dbg);
        chk("retire_cnt", bus.retire_cnt, m_cnt);
        chk("retire_cnt_w4", {28'd0, bus4.retire_cnt}, m_cnt % 16);
    endtask

    task automatic step();
        pre_checks();
        post_checks();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_dbg = 32'd0;
        m_cnt = 0;

        // 1) reset, then sweep all addresses
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        chk("rst_retire_cnt", bus.retire_cnt, 32'd0);
        chk("rst_dbg", bus.dbg_data, 32'd0);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(a), 5'(31 - a), 5'(a));
            pre_checks();
            chk("rst_rs_zero", bus.rs_data, 32'd0);
            chk("rst_rt_zero", bus.rt_data, 32'd0);
            post_checks();
            chk("rst_dbg_zero", bus.dbg_data, 32'd0);
        end

        // 2) ALU result write to r5, read back next cycle
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 5'd0);
        pre_checks();
        chk("t2_rs5", bus.rs_data, 32'h0000_1234);
        post_checks();
        chk("t2_cnt", bus.retire_cnt, 32'd1);

        // 3) same-cycle bypass on both ports, debug sees pre-write value
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd7, 5'd7, 5'd7, 5'd7);
        pre_checks();
        chk("t3_rs_bypass", bus.rs_data, 32'hDEAD_BEEF);
        chk("t3_rt_bypass", bus.rt_data, 32'hDEAD_BEEF);
        post_checks();
        chk("t3_dbg_old", bus.dbg_data, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd7);
        step();
        chk("t3_dbg_new", bus.dbg_data, 32'hDEAD_BEEF);

        // 4) write to r0 discarded
        drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        pre_checks();
        chk("t4_rs0", bus.rs_data, 32'd0);
        post_checks();
        chk("t4_cnt", bus.retire_cnt, 32'd2);

        // 5) WrReg=0: no commit, no bypass
        drive(1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3, 5'd3, 5'd3, 5'd3);
        pre_checks();
        chk("t5_rs3", bus.rs_data, 32'd0);
        post_checks();
        chk("t5_cnt", bus.retire_cnt, 32'd2);

        // 6) reset beats simultaneous write
        drive(1'b0, 1'b1, 1'b0, 32'h99, 32'h0, 5'd9, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h0, 32'hAA, 5'd9, 5'd0, 5'd0, 5'd0);
        step();
        chk("t6_cnt", bus.retire_cnt, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5, 5'd9);
        pre_checks();
        chk("t6_rs9", bus.rs_data, 32'd0);
        chk("t6_rt5", bus.rt_data, 32'd0);
        post_checks();

        // 6b) 16 commits wrap the 4-bit counter to 0
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'(i + 100), 32'h0, 5'(1 + (i % 31)), 5'd1, 5'd2, 5'd1);
            step();
        end
        chk("t6_w4_wrap", {28'd0, bus4.retire_cnt}, 32'd0);
        chk("t6_w32_16", bus.retire_cnt, 32'd16);

        // randomized traffic with occasional mid-stream reset
        for (int n = 0; n < 400; n++) begin
            logic [4:0] d;
            d = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, d,
                  ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
